round_key_sequencer: RTL and testbench

//  Consumes the full expanded key from keyExpansion and serves one 128-bit round key per

---
 rtl/aes_key_pkg.sv | 17 +
 rtl/round_key_sequencer_if.sv | 40 ++++
 rtl/round_key_sequencer_rk_select.sv | 23 ++
 rtl/round_key_sequencer.sv | 125 ++++++++++++
 tb/tb_round_key_sequencer.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_pkg.sv
// Shared AES-256 key-schedule definitions.
// Contents:
//   AES256_NK / AES256_NR  key words and cipher rounds for AES-256
//   RK_W                   round-key width in bits
//   SCHED_W                width of a complete expanded schedule (NR+1 round keys)
//   rks_state_t            round-key sequencer FSM states
package aes_key_pkg;
  localparam int AES256_NK = 8;
  localparam int AES256_NR = 14;
  localparam int RK_W      = 128;
  localparam int SCHED_W   = RK_W * (AES256_NR + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rks_state_t;
endpackage

// File: rtl/round_key_sequencer_if.sv
// Bus between the key-expansion / round datapath side (master) and the
// round-key sequencer (slave).
//
// Handshake rules:
//   load:  a schedule transfers on a cycle where load_valid && load_ready.
//          load_ready is high only while the sequencer is idle.
//   rk:    a round key transfers on a cycle where rk_valid && rk_ready.
//          While rk_valid=1 and rk_ready=0, rk_data/rk_index/rk_last hold.
//          start/dec/abort are single-cycle controls sampled at the clock edge.
// Signals:
//   load_valid, load_key[0:SCHED-1] (round r = load_key[128*r +: 128]), load_ready
//   start, dec, abort
//   rk_valid, rk_ready, rk_data, rk_index, rk_last, key_loaded
interface round_key_sequencer_if #(
  parameter int NUM_ROUNDS = 14,
  parameter int IDX_W      = 4
) ();
  logic                                           load_valid;
  logic                                           load_ready;
  logic [0:aes_key_pkg::RK_W*(NUM_ROUNDS+1)-1]    load_key;
  logic                                           start;
  logic                                           dec;
  logic                                           abort;
  logic                                           rk_valid;
  logic                                           rk_ready;
  logic [aes_key_pkg::RK_W-1:0]                   rk_data;
  logic [IDX_W-1:0]                               rk_index;
  logic                                           rk_last;
  logic                                           key_loaded;

  modport master (
    output load_valid, load_key, start, dec, abort, rk_ready,
    input  load_ready, rk_valid, rk_data, rk_index, rk_last, key_loaded
  );

  modport slave (
    input  load_valid, load_key, start, dec, abort, rk_ready,
    output load_ready, rk_valid, rk_data, rk_index, rk_last, key_loaded
  );
endinterface

// File: rtl/round_key_sequencer_rk_select.sv
// rk_select: combinational selection of one 128-bit round key out of an
// expanded schedule by round index. Indices above NUM_ROUNDS select zero.
// Ports:
//   i_sched  expanded schedule, round r at i_sched[RK_W*r +: RK_W]
//   i_idx    round index
//   o_rk     selected round key
module rk_select
  import aes_key_pkg::*;
#(
  parameter int NUM_ROUNDS = AES256_NR,
  parameter int IDX_W      = 4
) (
  input  logic [0:RK_W*(NUM_ROUNDS+1)-1] i_sched,
  input  logic [IDX_W-1:0]               i_idx,
  output logic [RK_W-1:0]                o_rk
);
  always_comb begin
    o_rk = '0;
    for (int r = 0; r <= NUM_ROUNDS; r++) begin
      if (i_idx == IDX_W'(r)) o_rk = i_sched[RK_W*r +: RK_W];
    end
  end
endmodule

// File: rtl/round_key_sequencer.sv
// round_key_sequencer: stores an AES-256 expanded key schedule and serves one
// round key per handshake, forward (0..NUM_ROUNDS) for encryption or reverse
// (NUM_ROUNDS..0) for decryption. The schedule persists across streams.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          round_key_sequencer_if.slave (load, start/dec/abort, rk stream)
//   o_dbg_state  current FSM state
// Build option:
//   RK_ZEROIZE_EN  when defined, the schedule and key_loaded clear at the end
//                  of every stream (final handshake or abort).
module round_key_sequencer
  import aes_key_pkg::*;
#(
  parameter int NUM_ROUNDS = AES256_NR,
  parameter int IDX_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  round_key_sequencer_if.slave        bus,
  output rks_state_t                  o_dbg_state
);
  localparam int               SCHED    = RK_W * (NUM_ROUNDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  rks_state_t       r_state;
  rks_state_t       w_next;
  logic [0:SCHED-1] r_sched;
  logic [IDX_W-1:0] r_cnt;
  logic             r_dec;
  logic             r_key_loaded;
  logic [RK_W-1:0]  r_rk_hold;
  logic [RK_W-1:0]  w_rk_sel;
  logic             w_load;
  logic             w_start;
  logic             w_step;
  logic             w_end;
  logic             w_last;

  // Direction-dependent end of stream; also gives rk_last its held value in IDLE.
  assign w_last = r_dec ? (r_cnt == '0) : (r_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_start = 1'b0;
    w_step  = 1'b0;
    w_end   = 1'b0;
    case (r_state)
      IDLE: begin
        w_load  = bus.load_valid;
        // A load in the same cycle takes priority and the start is dropped.
        w_start = bus.start && r_key_loaded && !bus.load_valid;
        if (w_start) w_next = STREAM;
      end
      STREAM: begin
        if (bus.abort || (bus.rk_ready && w_last)) begin
          w_next = IDLE;
          w_end  = 1'b1;
        end else if (bus.rk_ready) begin
          w_step = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter only steps on a non-final handshake, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dec <= 1'b0;
    end else if (w_start) begin
      r_dec <= bus.dec;
      r_cnt <= bus.dec ? LAST_IDX : '0;
    end else if (w_step) begin
      r_cnt <= r_dec ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sched      <= '0;
      r_key_loaded <= 1'b0;
    end else if (w_load) begin
      r_sched      <= bus.load_key;
      r_key_loaded <= 1'b1;
    end
`ifdef RK_ZEROIZE_EN
    else if (w_end) begin
      r_sched      <= '0;
      r_key_loaded <= 1'b0;
    end
`endif
  end

  // Captures the key on screen when a stream ends so rk_data stays stable in
  // IDLE even if the storage is later reloaded or zeroized.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_rk_hold <= '0;
    else if (w_end) r_rk_hold <= w_rk_sel;
  end

  rk_select #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .IDX_W      (IDX_W)
  ) u_rk_select (
    .i_sched (r_sched),
    .i_idx   (r_cnt),
    .o_rk    (w_rk_sel)
  );

  assign bus.load_ready = (r_state == IDLE);
  assign bus.rk_valid   = (r_state == STREAM);
  assign bus.rk_data    = (r_state == STREAM) ? w_rk_sel : r_rk_hold;
  assign bus.rk_index   = r_cnt;
  assign bus.rk_last    = w_last;
  assign bus.key_loaded = r_key_loaded;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_round_key_sequencer.sv
// Testbench for round_key_sequencer: FIPS-197 AES-256 key expanded by a
// behavioural model, forward/reverse streams, backpressure, abort, edge cases,
// asynchronous reset and randomized schedules with random consumer stalls.
module tb_round_key_sequencer;
  import aes_key_pkg::*;

  localparam int NR = 14;

  logic       clk;
  logic       rst;
  rks_state_t dbg_state;

  round_key_sequencer_if #(.NUM_ROUNDS(NR), .IDX_W(4)) bus ();

  round_key_sequencer #(.NUM_ROUNDS(NR), .IDX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] cur_rk [0:NR];
  logic [127:0] kat    [0:NR];
  bit           kat_v  [0:NR];
  bit           kat_on;
  logic [7:0]   sbox_t [0:255];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  task automatic model_fips_key();
    logic [255:0] key;
    logic [31:0]  w [0:59];
    logic [31:0]  t;
    logic [7:0]   rcon;
    key  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r <= NR; r++) cur_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    kat_on = 1'b1;
  endtask

  task automatic model_random_key();
    for (int r = 0; r <= NR; r++) cur_rk[r] = {$urandom, $urandom, $urandom, $urandom};
    kat_on = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    logic [0:128*(NR+1)-1] lk;
    for (int r = 0; r <= NR; r++) lk[128*r +: 128] = cur_rk[r];
    bus.load_key   = lk;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
  endtask

  // Starts a stream and scoreboards every cycle until the expected queue is
  // drained (or the abort index is reached). Consumer stalls are random
  // (ready_pct) and/or forced for 3 cycles at stall_idx.
  task automatic run_stream(input bit d, input int ready_pct, input int stall_idx,
                            input int abort_idx, input string nm, output int cycles);
    logic [127:0] exp_q[$];
    int           idx_q[$];
    int           stalls = 0;
    int           budget = 0;
    bit           rdy;
    bit           ab;
    bit           aborted = 1'b0;
    int           last_idx = 0;
    logic [127:0] last_data = '0;
    bit           last_last = 1'b0;
    for (int k = 0; k <= NR; k++) begin
      idx_q.push_back(d ? NR - k : k);
      exp_q.push_back(cur_rk[d ? NR - k : k]);
    end
    bus.start = 1'b1;
    bus.dec   = d;
    step();
    bus.start = 1'b0;
    cycles    = 0;
    while (idx_q.size() > 0 && !aborted && budget < 400) begin
      if (idx_q[0] == stall_idx && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      end
      ab = (idx_q[0] == abort_idx);
      if (ab) rdy = 1'b1;
      bus.rk_ready = rdy;
      bus.abort    = ab;
      @(negedge clk);
      cycles++;
      n_checks++;
      if (bus.rk_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s rk_valid: got %b expected 1", nm, bus.rk_valid);
      end
      n_checks++;
      if (bus.rk_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL %s rk_data idx%0d: got %h expected %h", nm, idx_q[0], bus.rk_data, exp_q[0]);
      end
      n_checks++;
      if (bus.rk_index !== 4'(idx_q[0])) begin
        n_fail++;
        $display("FAIL %s rk_index: got %0d expected %0d", nm, bus.rk_index, idx_q[0]);
      end
      n_checks++;
      if (bus.rk_last !== (idx_q.size() == 1)) begin
        n_fail++;
        $display("FAIL %s rk_last idx%0d: got %b expected %b", nm, idx_q[0], bus.rk_last, idx_q.size() == 1);
      end
      if (kat_on && kat_v[idx_q[0]]) begin
        n_checks++;
        if (bus.rk_data !== kat[idx_q[0]]) begin
          n_fail++;
          $display("FAIL %s fips idx%0d: got %h expected %h", nm, idx_q[0], bus.rk_data, kat[idx_q[0]]);
        end
      end
      if (rdy) begin
        last_idx  = idx_q.pop_front();
        last_data = exp_q.pop_front();
        last_last = (idx_q.size() == 0);
      end
      aborted = ab;
      step();
      budget++;
    end
    bus.rk_ready = 1'b0;
    bus.abort    = 1'b0;
    n_checks++;
    if (budget >= 400) begin
      n_fail++;
      $display("FAIL %s stream_budget: got %0d cycles expected < 400", nm, budget);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rk_valid !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL %s end_idle: got rk_valid=%b state=%0d expected 0/IDLE", nm, bus.rk_valid, dbg_state);
    end
    n_checks++;
    if (bus.rk_index !== 4'(last_idx) || bus.rk_data !== last_data || bus.rk_last !== last_last) begin
      n_fail++;
      $display("FAIL %s idle_hold: got idx=%0d last=%b data=%h expected idx=%0d last=%b data=%h",
               nm, bus.rk_index, bus.rk_last, bus.rk_data, last_idx, last_last, last_data);
    end
    n_checks++;
`ifdef RK_ZEROIZE_EN
    if (bus.key_loaded !== 1'b0) begin
      n_fail++;
      $display("FAIL %s key_loaded_after: got %b expected 0", nm, bus.key_loaded);
    end
`else
    if (bus.key_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL %s key_loaded_after: got %b expected 1", nm, bus.key_loaded);
    end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.rk_valid !== 1'b0 || bus.load_ready !== 1'b1 || bus.key_loaded !== 1'b0 ||
        bus.rk_last !== 1'b0 || bus.rk_index !== 4'd0 || bus.rk_data !== 128'h0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b lrdy=%b kl=%b last=%b idx=%0d data=%h st=%0d",
               bus.rk_valid, bus.load_ready, bus.key_loaded, bus.rk_last, bus.rk_index, bus.rk_data, dbg_state);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_start_without_key();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rk_valid !== 1'b0 || bus.key_loaded !== 1'b0) begin
        n_fail++;
        $display("FAIL start_no_key c%0d: got valid=%b kl=%b expected 0/0", c, bus.rk_valid, bus.key_loaded);
      end
    end
    step();
  endtask

  task automatic test_load_start_same_cycle();
    logic [0:128*(NR+1)-1] lk;
    model_fips_key();
    for (int r = 0; r <= NR; r++) lk[128*r +: 128] = cur_rk[r];
    bus.load_key   = lk;
    bus.load_valid = 1'b1;
    bus.start      = 1'b1;
    step();
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rk_valid !== 1'b0 || bus.key_loaded !== 1'b1) begin
        n_fail++;
        $display("FAIL load_and_start c%0d: got valid=%b kl=%b expected 0/1", c, bus.rk_valid, bus.key_loaded);
      end
    end
    step();
  endtask

  task automatic test_forward();
    int cyc;
    model_fips_key();
    do_load();
    run_stream(1'b0, 100, -1, -1, "forward", cyc);
    n_checks++;
    if (cyc != 15) begin
      n_fail++;
      $display("FAIL forward_cycles: got %0d expected 15", cyc);
    end
  endtask

  task automatic test_reverse();
    int cyc;
    model_fips_key();
    do_load();
    run_stream(1'b1, 100, -1, -1, "reverse", cyc);
    n_checks++;
    if (cyc != 15) begin
      n_fail++;
      $display("FAIL reverse_cycles: got %0d expected 15", cyc);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    model_fips_key();
    do_load();
    run_stream(1'b0, 100, 5, -1, "backpressure", cyc);
    n_checks++;
    if (cyc != 18) begin
      n_fail++;
      $display("FAIL backpressure_cycles: got %0d expected 18", cyc);
    end
  endtask

  task automatic test_abort();
    int cyc;
    model_fips_key();
    do_load();
    run_stream(1'b0, 100, -1, 7, "abort", cyc);
    n_checks++;
    if (cyc != 8) begin
      n_fail++;
      $display("FAIL abort_cycles: got %0d expected 8", cyc);
    end
`ifdef RK_ZEROIZE_EN
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rk_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_zeroized_start c%0d: got valid=%b expected 0", c, bus.rk_valid);
      end
    end
    step();
`else
    run_stream(1'b0, 100, -1, -1, "abort_replay", cyc);
`endif
  endtask

  task automatic test_load_in_stream();
    logic [0:128*(NR+1)-1] junk;
    model_fips_key();
    do_load();
    for (int r = 0; r <= NR; r++) junk[128*r +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.start = 1'b1;
    bus.dec   = 1'b0;
    step();
    bus.start      = 1'b0;
    bus.load_key   = junk;
    bus.load_valid = 1'b1;
    bus.rk_ready   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.load_ready !== 1'b0 || bus.rk_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL load_in_stream_ready: got lrdy=%b valid=%b expected 0/1", bus.load_ready, bus.rk_valid);
    end
    step();
    bus.load_valid = 1'b0;
    bus.rk_ready   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rk_data !== cur_rk[0]) begin
      n_fail++;
      $display("FAIL load_in_stream_idx0: got %h expected %h", bus.rk_data, cur_rk[0]);
    end
    step();
    bus.abort = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rk_data !== cur_rk[1] || bus.rk_index !== 4'd1) begin
      n_fail++;
      $display("FAIL load_in_stream_idx1: got idx=%0d data=%h expected 1 %h", bus.rk_index, bus.rk_data, cur_rk[1]);
    end
    step();
    bus.abort    = 1'b0;
    bus.rk_ready = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    model_fips_key();
    do_load();
    bus.start = 1'b1;
    bus.dec   = 1'b0;
    step();
    bus.start    = 1'b0;
    bus.rk_ready = 1'b1;
    repeat (3) step();
    bus.rk_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rk_index !== 4'd3 || bus.rk_data !== cur_rk[3]) begin
      n_fail++;
      $display("FAIL async_pre_idx3: got idx=%0d data=%h expected 3 %h", bus.rk_index, bus.rk_data, cur_rk[3]);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.rk_valid !== 1'b0 || bus.key_loaded !== 1'b0 || bus.rk_index !== 4'd0 ||
        bus.rk_data !== 128'h0 || bus.rk_last !== 1'b0 || bus.load_ready !== 1'b1 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL async_reset_now: got valid=%b kl=%b idx=%0d last=%b lrdy=%b data=%h",
               bus.rk_valid, bus.key_loaded, bus.rk_index, bus.rk_last, bus.load_ready, bus.rk_data);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rk_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL async_restart_no_key c%0d: got valid=%b expected 0", c, bus.rk_valid);
      end
    end
    step();
  endtask

  task automatic test_repeat_start();
    int cyc;
    model_fips_key();
    do_load();
    run_stream(1'b0, 100, -1, -1, "repeat_first", cyc);
`ifdef RK_ZEROIZE_EN
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rk_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL repeat_zeroized c%0d: got valid=%b expected 0", c, bus.rk_valid);
      end
    end
    step();
`else
    run_stream(1'b1, 100, -1, -1, "repeat_second", cyc);
`endif
  endtask

  task automatic test_random();
    int cyc;
    for (int it = 0; it < 6; it++) begin
      model_random_key();
      do_load();
      run_stream(1'($urandom_range(0, 1)), 60, -1, -1, "random", cyc);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_key   = '0;
    bus.start      = 1'b0;
    bus.dec        = 1'b0;
    bus.abort      = 1'b0;
    bus.rk_ready   = 1'b0;
    for (int r = 0; r <= NR; r++) begin
      kat[r]   = '0;
      kat_v[r] = 1'b0;
    end
    kat[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    kat[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    kat[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    kat[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    kat_v[0] = 1'b1;
    kat_v[1] = 1'b1;
    kat_v[2] = 1'b1;
    kat_v[14] = 1'b1;
    kat_on = 1'b0;
    build_sbox();

    test_reset();
    test_start_without_key();
    test_load_start_same_cycle();
    test_forward();
    test_reverse();
    test_backpressure();
    test_abort();
    test_load_in_stream();
    test_repeat_start();
    test_async_reset();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
